dm_cache_responder: RTL

- Responder end of the CPU memory interface that the core's I-side and D-side ports drive (address/read/write/wdata/mbe, answered by resp/rdata).
- Direct-mapped, write-back, write-allocate L1 cache with one outstanding request.
- Returns 32-bit words to the core; fills and evicts 256-bit lines over a physical-memory port.
- One instance per core port. The same RTL serves as I-cache (writes never issued) and as D-cache.

---
 rtl/dm_cache_responder_pkg.sv | 10 +
 rtl/dm_cache_responder_data_array.sv | 19 +
 rtl/dm_cache_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dm_cache_responder_pkg.sv
// dm_cache_types: shared state encoding, line geometry and byte-mask helper for the cache responder
package dm_cache_types;
  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE} state_e;
  localparam int S_OFFSET = 5;
  localparam int LINE_W = 256;
  typedef logic [LINE_W-1:0] line_t;
  function automatic logic [31:0] line_byte_mask(input logic [3:0] mbe, input logic [2:0] word);
    return 32'(mbe) << {word, 2'b00};
  endfunction
endpackage

// File: rtl/dm_cache_responder_data_array.sv
// dm_cache_data_array: line storage with per-byte write enables and asynchronous read
module dm_cache_data_array
  import dm_cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic               clk,
  input  logic [S_INDEX-1:0] idx_i,
  input  logic [31:0]        we_i,
  input  line_t              wdata_i,
  output line_t              rdata_o
);
  line_t lines_q [2**S_INDEX];
  always_ff @(posedge clk) begin
    for (int b = 0; b < 32; b++)
      if (we_i[b]) lines_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
  end
  assign rdata_o = lines_q[idx_i];
endmodule

// File: rtl/dm_cache_responder.sv
// dm_cache_responder: direct-mapped write-back write-allocate L1 responder, one request in flight.
// Optional perf_hits/perf_misses counters under DM_CACHE_PERF_COUNTERS_EN.
module dm_cache_responder
  import dm_cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output line_t       pmem_wdata,
  input  line_t       pmem_rdata,
  input  logic        pmem_resp
`ifdef DM_CACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  localparam int SETS = 2**S_INDEX;
  localparam int S_TAG = 27 - S_INDEX;
  state_e state_q, state_d;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] mbe_q;
  logic write_q;
  logic [SETS-1:0] valid_q, dirty_q;
  logic [S_TAG-1:0] tag_q [SETS];
  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0] req_tag;
  logic hit;
  line_t line, wline;
  logic [31:0] we;
  logic unused;
  assign unused = ^mem_address[1:0];
  assign idx = addr_q[S_OFFSET +: S_INDEX];
  assign req_tag = addr_q[31 -: S_TAG];
  assign hit = valid_q[idx] && tag_q[idx] == req_tag;
  dm_cache_data_array #(.S_INDEX(S_INDEX)) u_data (
    .clk     (clk),
    .idx_i   (idx),
    .we_i    (we),
    .wdata_i (wline),
    .rdata_o (line)
  );
  always_comb begin
    state_d = state_q;
    mem_resp = 1'b0;
    mem_rdata = '0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    we = '0;
    wline = {8{wdata_q}};
    case (state_q)
      IDLE: state_d = (mem_read || mem_write) ? LOOKUP : IDLE;
      LOOKUP: begin
        mem_resp = hit;
        mem_rdata = hit ? line[{addr_q[4:2], 5'd0} +: 32] : '0;
        we = (hit && write_q) ? line_byte_mask(mbe_q, addr_q[4:2]) : '0;
        state_d = hit ? IDLE : (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = {tag_q[idx], idx, 5'd0};
        pmem_wdata = line;
        state_d = pmem_resp ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        pmem_address = {req_tag, idx, 5'd0};
        wline = pmem_rdata;
        we = pmem_resp ? '1 : '0;
        state_d = pmem_resp ? LOOKUP : ALLOCATE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        addr_q <= mem_address[31:2];
        wdata_q <= mem_wdata;
        mbe_q <= mem_byte_enable;
        write_q <= mem_write;
      end
      if (state_q == LOOKUP && hit && write_q) dirty_q[idx] <= 1'b1;
      if (state_q == WRITEBACK && pmem_resp) dirty_q[idx] <= 1'b0;
      if (state_q == ALLOCATE && pmem_resp) begin
        tag_q[idx] <= req_tag;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end
`ifdef DM_CACHE_PERF_COUNTERS_EN
  // the LOOKUP right after a fill replays an already-counted miss
  logic refill_q;
  logic [31:0] hits_q, misses_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_q <= 1'b0;
      hits_q <= '0;
      misses_q <= '0;
    end else begin
      refill_q <= state_q == ALLOCATE;
      if (state_q == LOOKUP && !refill_q) begin
        hits_q <= hit ? hits_q + 32'd1 : hits_q;
        misses_q <= hit ? misses_q : misses_q + 32'd1;
      end
    end
  end
  assign perf_hits = hits_q;
  assign perf_misses = misses_q;
`endif
endmodule
